bram_arbiter: RTL



---
 rtl/bram_arbiter_pkg.sv | 25 ++
 rtl/bram_arbiter_rr_pick2.sv | 21 ++
 rtl/bram_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/bram_arbiter_pkg.sv
// Shared encodings for the two-port BRAM block-transfer arbiter.
package bram_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_BUSY  = 2'd2;
  localparam logic [1:0] ARB_COOL  = 2'd3;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef logic [1:0] arb_state_t;

  localparam int COOL_W = 3;

  // Cooldown counter reload; out-of-range settings are pulled into 1..7.
  function automatic logic [COOL_W-1:0] cool_reload(input int cycles);
    int c;
    c = cycles;
    if (c < 1) c = 1;
    if (c > 7) c = 7;
    return COOL_W'(c - 1);
  endfunction

endpackage

// File: rtl/bram_arbiter_rr_pick2.sv
// Two-way request picker: round-robin against the last owner, or port 1 fixed-wins.
module bram_arbiter_rr_pick2 #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic any,
  output logic winner
);

  always_comb begin
    any    = req0 | req1;
    winner = req1;
    if (req0 && req1) begin
      if (FIXED_PRIORITY != 0) winner = 1'b1;
      else                     winner = ~last_grant;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one block-transfer BRAM controller between the I-cache (port 0) and D-cache (port 1).
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int FIXED_PRIORITY  = 0,
  parameter int COOLDOWN_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m1_req,
  input  logic                  m0_rw,
  input  logic                  m1_rw,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_wdata_req,
  output logic                  m1_wdata_req,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic                  m0_done,
  output logic                  m1_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req_op,
  output logic                  mem_rw,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_wdata_req,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  input  logic                  mem_finished
);

  localparam logic [COOL_W-1:0] COOL_LOAD = cool_reload(COOLDOWN_CYCLES);

  arb_state_t        state;
  logic              grant;
  logic              last_grant;
  logic [COOL_W-1:0] cool_cnt;
  logic              pick_any;
  logic              pick_winner;
  logic              xfer;
  logic              busy;

  bram_arbiter_rr_pick2 #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_pick (
    .req0      (m0_req),
    .req1      (m1_req),
    .last_grant(last_grant),
    .any       (pick_any),
    .winner    (pick_winner)
  );

  // Requester address/rw are captured at grant; later cycles use only the latched copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      mem_req_op <= 1'b0;
      mem_addr   <= '0;
      mem_rw     <= MEM_READ;
      cool_cnt   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant      <= pick_winner;
            mem_addr   <= pick_winner ? m1_addr : m0_addr;
            mem_rw     <= pick_winner ? m1_rw : m0_rw;
            mem_req_op <= 1'b1;
            state      <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          mem_req_op <= 1'b0;
          last_grant <= grant;
          state      <= ARB_BUSY;
        end
        ARB_BUSY: begin
          if (mem_finished) begin
            cool_cnt <= COOL_LOAD;
            state    <= ARB_COOL;
          end
        end
        ARB_COOL: begin
          if (cool_cnt == '0) state <= ARB_IDLE;
          else                cool_cnt <= cool_cnt - 1'b1;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign xfer = (state == ARB_ISSUE) || (state == ARB_BUSY);
  assign busy = (state == ARB_BUSY);

  // Data steering follows the registered grant; nothing leaks out in IDLE/COOL.
  always_comb begin
    mem_wdata = '0;
    if (xfer) mem_wdata = grant ? m1_wdata : m0_wdata;
  end

  assign m0_wdata_req = mem_wdata_req & xfer & ~grant;
  assign m1_wdata_req = mem_wdata_req & xfer &  grant;
  assign m0_rvalid    = mem_rvalid    & xfer & ~grant;
  assign m1_rvalid    = mem_rvalid    & xfer &  grant;
  assign m0_done      = mem_finished  & busy & ~grant;
  assign m1_done      = mem_finished  & busy &  grant;
  assign m0_rdata     = mem_rdata;
  assign m1_rdata     = mem_rdata;

endmodule
